wash_controller: RTL
====================

# wash_controller

Program sequencer for the washing machine: owns the machine state, the selected program, the phase walk and the remaining-time countdown. Drives the display/LED view block's `state`, `data`, `shinning`, `inLeft/inMiddle/inRight` and `second` inputs. Buttons arrive as debounced single-cycle pulses.

## Interface
- `TICKS_PER_SEC`, 50_000_000, cp cycles per second (must be even, ≥2).
- `BEGIN_S`, 2, lamp-test duration in seconds.
- `FINISH_S`, 3, finish-display duration in seconds.
- `cp`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `power_btn`  in  1  pulse; power on/off toggle.
- `start_btn`  in  1  pulse; start / pause / resume.
- `mode_btn`  in  1  pulse; next program (setST only).
- `door_open`  in  1  level; lid sensor.
- `state`  out  3  0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish.
- `data`  out  10  [9] set LED, [8] power LED, [7:0] remaining-phase mask.
- `shinning`  out  3  current phase index; 0 maps to `data[7]`, 7 to `data[0]`.
- `second`  out  1  blink: high in first half of each second.
- `inLeft`, `inMiddle`, `inRight`  out  6 each  program number, remaining-seconds tens, ones.

## Operation
- Phases 0..7: in-water 3 s, wash 9 s, rinse-out 3 s, rinse-spin 3 s, rinse-in 3 s, rinse 6 s, dry-out 3 s, dry-spin 3 s.
- Programs (mask bit 7 = phase 0): P1 8'hFF (33 s), P2 8'hC0, P3 8'h3F, P4 8'h03, P5 8'hC3.
- shutDown: all outputs 0. `power_btn` → begin.
- begin: hold BEGIN_S ticks → set with program = P1.
- set: `mode_btn` advances program P1→…→P5→P1. The mask and the total time are shown. `start_btn` → run, with `shinning` = first set mask bit and remaining = program total. If `door_open` (macro on), `start_btn` → error instead.
- run: each tick decrements the phase counter and the total. When the phase counter reaches 0, clear that mask bit and load the next set bit's duration. The last phase reaching 0 → finish. `start_btn` → pause.
- pause: all counters frozen. `start_btn` → run.
- error: frozen. `door_open` low → pause.
- finish: hold FINISH_S ticks → shutDown.
- Priority per cycle: `rst` > `power_btn` (any non-shutDown state → shutDown) > `door_open` > `start_btn`/`mode_btn` > tick.
- A tick in the same cycle as a winning button is discarded.
- `data[8]` = 1 in every state except shutDown. `data[9]` = 1 only in set.
- Digits are the binary 0..9 values. Remaining time is always ≤ 99.

## Timing
- All outputs are registered and reflect an event on the cycle after it.
- Reset values: `state`=0, `data`=0, `shinning`=0, `second`=0, all digits 0, internal program = P1, divider = 0.
- Tick: one-cycle pulse when the divider wraps at TICKS_PER_SEC−1. The divider free-runs and is cleared on entry to run, begin and finish, so the first tick comes a full second after entry.
- `second` = 1 while divider < TICKS_PER_SEC/2, else 0.
- Phase change: the mask bit clears and `shinning` moves in the same cycle that the counter hits 0. There are no idle cycles between phases.
- `rst` mid-run: returns to shutDown on the next edge and drops all progress.

## Configuration
- `DOOR_LOCK_EN` defined: `door_open` forces run/set-start → error, as described above.
- `DOOR_LOCK_EN` undefined: `door_open` is ignored, error is unreachable, and the port remains.

## Structure
- Package `wash_pkg`: state encodings (0..6), phase durations, program mask table, program count.
- Sub-module `tick_gen`: divider producing the `tick` pulse and `second`, with a `clr` input.
- FSM, phase walker and countdown stay in `wash_controller`.

## Test plan
Run with TICKS_PER_SEC=4.
- Reset, then `power_btn` → `state`=1 for 8 cycles, then `state`=2, `inLeft`=1, `data`=10'h3FF, `inMiddle`=3, `inRight`=3.
- `mode_btn` ×5 in set → `inLeft` 2,3,4,5,1. At P2, mask 8'hC0 and digits 1,2.
- P4 start → `shinning`=6, digits 0,6. After 12 cycles `shinning`=7, mask 8'h01. After 24 cycles `state`=6. Then `state`=0 after a further 12 cycles.
- Run P1; `start_btn` at remaining 30 → `state`=5 with digits frozen for 40 cycles. `start_btn` → resumes counting down from 30.
- `DOOR_LOCK_EN`: `door_open` during run → `state`=4. Release → `state`=5. Without the macro, `state` stays 3.
- `power_btn` and a tick in the same cycle during run → `state`=0 and `data`=0, with no decrement applied.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared encodings, phase durations and program table for the wash sequencer.
// Helpers: per-phase duration, program mask, first pending phase, mask total time.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_BEGIN = 3'd1,
    ST_SET   = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4,
    ST_PAUSE = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  localparam int NUM_PROG = 5;

  function automatic logic [3:0] ph_dur(input logic [2:0] p);
    case (p)
      3'd1:    ph_dur = 4'd9;
      3'd5:    ph_dur = 4'd6;
      default: ph_dur = 4'd3;
    endcase
  endfunction

  function automatic logic [7:0] prog_mask(input logic [2:0] p);
    case (p)
      3'd1:    prog_mask = 8'hC0;
      3'd2:    prog_mask = 8'h3F;
      3'd3:    prog_mask = 8'h03;
      3'd4:    prog_mask = 8'hC3;
      default: prog_mask = 8'hFF;
    endcase
  endfunction

  // Phase p lives in mask bit 7-p.
  function automatic logic [7:0] ph_bit(input logic [2:0] p);
    ph_bit = 8'h80 >> p;
  endfunction

  function automatic logic [2:0] first_ph(input logic [7:0] m);
    first_ph = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[7-i]) first_ph = 3'(i);
  endfunction

  function automatic logic [6:0] mask_total(input logic [7:0] m);
    mask_total = '0;
    for (int i = 0; i < 8; i++)
      if (m[7-i]) mask_total = mask_total + 7'(ph_dur(3'(i)));
  endfunction

endpackage

// File: rtl/wash_controller_if.sv
// Panel-side bundle: debounced button pulses and lid level in, display view out.
// master = panel/testbench side, slave = wash_controller.
interface wash_controller_if;
  logic       power_btn;
  logic       start_btn;
  logic       mode_btn;
  logic       door_open;
  logic [2:0] state;
  logic [9:0] data;
  logic [2:0] shinning;
  logic       second;
  logic [5:0] inLeft;
  logic [5:0] inMiddle;
  logic [5:0] inRight;

  modport master (
    output power_btn, start_btn, mode_btn, door_open,
    input  state, data, shinning, second,
    input  inLeft, inMiddle, inRight
  );

  modport slave (
    input  power_btn, start_btn, mode_btn, door_open,
    output state, data, shinning, second,
    output inLeft, inMiddle, inRight
  );
endinterface

// File: rtl/wash_controller_tick_gen.sv
// One-second divider: tick pulses on wrap, second is high in the first half.
// Ports: cp, rst (sync, high), clr (restart count), tick, second.
module tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic cp,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic second
);

  localparam int W = $clog2(TICKS_PER_SEC);
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);
  localparam logic [W-1:0] HALF = W'(TICKS_PER_SEC / 2);

  logic [W-1:0] div;

  assign tick   = (div == LAST);
  assign second = (div < HALF);

  always_ff @(posedge cp) begin
    if (rst)       div <= '0;
    else if (clr)  div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

endmodule

// File: rtl/wash_controller.sv
// Washing-machine program sequencer: FSM, phase walker and countdown.
// Ports: cp, rst (sync, high), bus (slave). Option macro: DOOR_LOCK_EN.
module wash_controller
  import wash_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int BEGIN_S       = 2,
  parameter int FINISH_S      = 3
) (
  input  logic           cp,
  input  logic           rst,
  wash_controller_if.slave bus
);

  state_t     st, n_st;
  logic [2:0] prog, n_prog;
  logic [2:0] ph, n_ph;
  logic [7:0] mask, n_mask;
  logic [3:0] ph_cnt, n_ph_cnt;
  logic [6:0] rem, n_rem;
  logic [7:0] hold, n_hold;
  logic [7:0] rest;
  logic [2:0] ld_prog;
  logic       ld, wipe, clr;
  logic       tick, sec, door, on;

`ifdef DOOR_LOCK_EN
  assign door = bus.door_open;
`else
  assign door = 1'b0;
`endif

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick (
    .cp    (cp),
    .rst   (rst),
    .clr   (clr),
    .tick  (tick),
    .second(sec)
  );

  always_ff @(posedge cp) begin
    if (rst) begin
      st     <= ST_OFF;
      prog   <= '0;
      ph     <= '0;
      mask   <= '0;
      ph_cnt <= '0;
      rem    <= '0;
      hold   <= '0;
    end else begin
      st     <= n_st;
      prog   <= n_prog;
      ph     <= n_ph;
      mask   <= n_mask;
      ph_cnt <= n_ph_cnt;
      rem    <= n_rem;
      hold   <= n_hold;
    end
  end

  always_comb begin
    n_st     = st;
    n_prog   = prog;
    n_ph     = ph;
    n_mask   = mask;
    n_ph_cnt = ph_cnt;
    n_rem    = rem;
    n_hold   = hold;
    rest     = mask & ~ph_bit(ph);
    ld_prog  = '0;
    ld       = 1'b0;
    wipe     = 1'b0;
    clr      = 1'b0;

    if (st == ST_OFF) begin
      if (bus.power_btn) begin
        n_st   = ST_BEGIN;
        n_hold = '0;
        clr    = 1'b1;
        ld     = 1'b1;
      end
    end else if (bus.power_btn) begin
      n_st = ST_OFF;
      wipe = 1'b1;
    end else begin
      unique case (st)
        ST_BEGIN: begin
          if (tick) begin
            if (hold == 8'(BEGIN_S - 1)) begin
              n_st = ST_SET;
              ld   = 1'b1;
            end else begin
              n_hold = hold + 8'd1;
            end
          end
        end
        ST_SET: begin
          // Run context is preloaded while browsing, so start only moves state.
          if (bus.start_btn) begin
            if (door) begin
              n_st = ST_ERR;
            end else begin
              n_st = ST_RUN;
              clr  = 1'b1;
            end
          end else if (bus.mode_btn) begin
            ld = 1'b1;
            if (prog == 3'(NUM_PROG - 1)) ld_prog = '0;
            else ld_prog = prog + 3'd1;
          end
        end
        ST_RUN: begin
          if (door) begin
            n_st = ST_ERR;
          end else if (bus.start_btn) begin
            n_st = ST_PAUSE;
          end else if (tick) begin
            n_rem = rem - 7'd1;
            if (ph_cnt == 4'd1) begin
              n_mask = rest;
              if (rest == '0) begin
                n_st   = ST_FIN;
                n_hold = '0;
                clr    = 1'b1;
              end else begin
                n_ph     = first_ph(rest);
                n_ph_cnt = ph_dur(first_ph(rest));
              end
            end else begin
              n_ph_cnt = ph_cnt - 4'd1;
            end
          end
        end
        ST_PAUSE: begin
          // An open lid keeps the cycle parked instead of bouncing to error.
          if (bus.start_btn && !door) begin
            n_st = ST_RUN;
            clr  = 1'b1;
          end
        end
        ST_ERR: begin
          if (!bus.door_open) n_st = ST_PAUSE;
        end
        ST_FIN: begin
          if (tick) begin
            if (hold == 8'(FINISH_S - 1)) begin
              n_st = ST_OFF;
              wipe = 1'b1;
            end else begin
              n_hold = hold + 8'd1;
            end
          end
        end
        default: n_st = ST_OFF;
      endcase
    end

    if (ld) begin
      n_prog   = ld_prog;
      n_mask   = prog_mask(ld_prog);
      n_ph     = first_ph(prog_mask(ld_prog));
      n_ph_cnt = ph_dur(first_ph(prog_mask(ld_prog)));
      n_rem    = mask_total(prog_mask(ld_prog));
    end

    if (wipe) begin
      n_prog   = '0;
      n_ph     = '0;
      n_mask   = '0;
      n_ph_cnt = '0;
      n_rem    = '0;
      n_hold   = '0;
    end
  end

  assign on           = (st != ST_OFF);
  assign bus.state    = st;
  assign bus.data     = on ? {st == ST_SET, 1'b1, mask} : '0;
  assign bus.shinning = on ? ph : '0;
  assign bus.second   = on & sec;
  assign bus.inLeft   = on ? 6'(prog) + 6'd1 : '0;
  assign bus.inMiddle = on ? 6'(rem / 7'd10) : '0;
  assign bus.inRight  = on ? 6'(rem % 7'd10) : '0;

endmodule
